// File: rtl/prio_scan_pkg.sv
// Shared mode codes, FSM states and search-direction type for the
// sequential priority scan arbiter and its chunk encoder.
package prio_scan_pkg;

    localparam logic [1:0] MODE_LOW  = 2'd0;
    localparam logic [1:0] MODE_HIGH = 2'd1;
    localparam logic [1:0] MODE_RR   = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Which end of a chunk wins when several bits are set.
    typedef enum logic {
        DIR_LOW  = 1'b0,
        DIR_HIGH = 1'b1
    } dir_t;

    // The reserved mode code behaves exactly like LOW.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_HIGH || m == MODE_RR) ? m : MODE_LOW;
    endfunction

endpackage

// File: rtl/prio_chunk_enc.sv
// Combinational priority encoder over one CHUNK-wide slice of the request
// vector. Only bits enabled by mask compete; dir selects lowest or highest.
module prio_chunk_enc
    import prio_scan_pkg::*;
#(
    parameter int CHUNK = 16,
    parameter int IW    = $clog2(CHUNK)
) (
    input  logic [CHUNK-1:0] bits,
    input  logic [CHUNK-1:0] mask,
    input  dir_t             dir,
    output logic             hit,
    output logic [IW-1:0]    idx
);

    logic [CHUNK-1:0] eligible;

    // Pick the winning eligible bit: the last match in scan order wins.
    always_comb begin
        // NOTE: every output gets a default before the loops, so no path leaves a latch behind.
        eligible = bits & mask;
        hit      = |eligible;
        idx      = '0;
        if (dir == DIR_HIGH) begin
            for (int i = 0; i < CHUNK; i++) begin
                if (eligible[i]) idx = IW'(i);
            end
        end else begin
            for (int i = CHUNK - 1; i >= 0; i--) begin
                if (eligible[i]) idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/prio_scan_arbiter.sv
// Sequential priority encoder / arbiter. A snapshot of the request vector is
// searched CHUNK lines per clock in LOW, HIGH or round-robin order, so wide
// vectors (e.g. the 128-note active bitmap) close timing.
module prio_scan_arbiter
    import prio_scan_pkg::*;
#(
    parameter int LINES = 128,
    parameter int WIDTH = $clog2(LINES),
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [LINES-1:0] in,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rr_ptr
);

    localparam int NCHUNK = LINES / CHUNK;
    localparam int CW     = $clog2(CHUNK);
    localparam int NW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int SW     = $clog2(NCHUNK + 2);

    state_t           state;
    logic [LINES-1:0] snap;
    logic [1:0]       smode;
    logic [NW-1:0]    chunk;
    logic [SW-1:0]    step;
    logic [CW-1:0]    s_local;

    logic [WIDTH-1:0] s_next;
    logic [CHUNK-1:0] cur_bits;
    logic [CHUNK-1:0] scan_mask;
    logic             last_step;
    logic             enc_hit;
    logic [CW-1:0]    enc_idx;
    logic [WIDTH-1:0] hit_index;
    logic [NW-1:0]    next_chunk;

    // Round-robin search begins one past the last grant (wraps naturally).
    assign s_next    = rr_ptr + 1'b1;
    assign cur_bits  = snap[int'(chunk) * CHUNK +: CHUNK];
    assign hit_index = (WIDTH'(chunk) << CW) | WIDTH'(enc_idx);
    assign last_step = (smode == MODE_RR) ? (step == SW'(NCHUNK))
                                          : (step == SW'(NCHUNK - 1));

    // RR: the first visit to the start chunk keeps bits >= s, the final
    // revisit keeps bits < s; every other step sees the whole chunk.
    always_comb begin
        scan_mask = '1;
        if (smode == MODE_RR) begin
            if (step == '0) begin
                scan_mask = {CHUNK{1'b1}} << s_local;
            end else if (step == SW'(NCHUNK)) begin
                scan_mask = ~({CHUNK{1'b1}} << s_local);
            end
        end
    end

    // Chunk order: HIGH descends, LOW and RR ascend with wrap.
    always_comb begin
        if (smode == MODE_HIGH) begin
            next_chunk = chunk - 1'b1;
        end else if (chunk == NW'(NCHUNK - 1)) begin
            next_chunk = '0;
        end else begin
            next_chunk = chunk + 1'b1;
        end
    end

    prio_chunk_enc #(
        .CHUNK (CHUNK)
    ) u_enc (
        .bits (cur_bits),
        .mask (scan_mask),
        .dir  ((smode == MODE_HIGH) ? DIR_HIGH : DIR_LOW),
        .hit  (enc_hit),
        .idx  (enc_idx)
    );

    // IDLE -> SCAN -> IDLE controller with registered status and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: snap/smode/chunk/step/s_local are left unreset; IDLE always loads them before SCAN reads them.
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            found  <= 1'b0;
            out    <= '0;
            rr_ptr <= WIDTH'(LINES - 1);
        end else begin
            // NOTE: non-blocking assignments, so every branch sees the pre-edge register values.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        snap    <= in;
                        smode   <= norm_mode(mode);
                        step    <= '0;
                        s_local <= s_next[CW-1:0];
                        case (norm_mode(mode))
                            MODE_HIGH: chunk <= NW'(NCHUNK - 1);
                            MODE_RR:   chunk <= NW'(s_next >> CW);
                            default:   chunk <= '0;
                        endcase
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (enc_hit || last_step) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        found <= enc_hit;
                        out   <= enc_hit ? hit_index : '0;
                        if (enc_hit && smode == MODE_RR) rr_ptr <= hit_index;
                        state <= ST_IDLE;
                    end else begin
                        chunk <= next_chunk;
                        step  <= step + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_scan_arbiter.sv
// Scoreboard bench for prio_scan_arbiter (LINES=128, CHUNK=16). Stimulus
// pushes the reference model's answer; a negedge monitor pops on done.
module tb_prio_scan_arbiter;
    import prio_scan_pkg::*;

    localparam int LINES  = 128;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = LINES / CHUNK;
    localparam int WIDTH  = 7;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             start  = 1'b0;
    logic [1:0]       mode   = 2'd0;
    logic [LINES-1:0] vec_in = '0;
    logic             busy;
    logic             done;
    logic             found;
    logic [WIDTH-1:0] out_idx;
    logic [WIDTH-1:0] rr_ptr;

    prio_scan_arbiter #(
        .LINES (LINES),
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .mode   (mode),
        .in     (vec_in),
        .busy   (busy),
        .done   (done),
        .found  (found),
        .out    (out_idx),
        .rr_ptr (rr_ptr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int found;
        int idx;
        int rr;
        int k;
        int c0;
    } exp_t;

    exp_t exp_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    int   model_rr = LINES - 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: search the whole vector in the mode's order, then count how
    // many CHUNK-sized blocks the sequential search had to visit.
    function automatic exp_t model(input logic [1:0] m, input logic [LINES-1:0] v, input int rr);
        exp_t e;
        int s, cs, g;
        e.found = 0; e.idx = 0; e.rr = rr; e.c0 = 0;
        if (m == MODE_HIGH) begin
            for (int i = 0; i < LINES; i++) if (v[i]) begin e.found = 1; e.idx = i; end
            e.k = e.found ? NCHUNK - e.idx / CHUNK : NCHUNK;
        end else if (m == MODE_RR) begin
            s  = (rr + 1) % LINES;
            cs = s / CHUNK;
            for (int j = LINES - 1; j >= 0; j--) begin
                g = (s + j) % LINES;
                if (v[g]) begin e.found = 1; e.idx = g; end
            end
            if (!e.found)                  e.k = NCHUNK + 1;
            else if (e.idx >= s)           e.k = e.idx / CHUNK - cs + 1;
            else if (e.idx / CHUNK == cs)  e.k = NCHUNK + 1;
            else                           e.k = (e.idx / CHUNK - cs + NCHUNK) % NCHUNK + 1;
            if (e.found) e.rr = e.idx;
        end else begin
            for (int i = LINES - 1; i >= 0; i--) if (v[i]) begin e.found = 1; e.idx = i; end
            e.k = e.found ? e.idx / CHUNK + 1 : NCHUNK;
        end
        return e;
    endfunction

    function automatic logic [LINES-1:0] rand_vec();
        logic [LINES-1:0] v;
        int r;
        v = '0;
        r = $urandom_range(0, 9);
        if (r == 1) begin
            v = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else if (r != 0) begin
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) v[$urandom_range(0, LINES - 1)] = 1'b1;
        end
        return v;
    endfunction

    // Wait for idle, present one request, then scramble the live inputs so
    // the DUT must rely on its snapshot. hold keeps start high while busy.
    task automatic issue(input logic [1:0] m, input logic [LINES-1:0] v,
                         input bit hold, input bit expect_done);
        exp_t e;
        int   budget = 0;
        while (busy && budget < 40) begin
            @(posedge clk); #1;
            budget++;
        end
        check("idle_wait", int'(busy), 0);
        mode   = m;
        vec_in = v;
        start  = 1'b1;
        e = model(m, v, model_rr);
        @(posedge clk); #1;
        e.c0 = cyc;
        if (expect_done) begin
            exp_q.push_back(e);
            model_rr = e.rr;
        end
        vec_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode   = 2'($urandom());
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_q.size() != 0 || busy) && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        check("drain_pending", exp_q.size() + int'(busy), 0);
        exp_q.delete();
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unrequested_done_queue", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("found", int'(found), e.found);
                check("out", int'(out_idx), e.idx);
                check("rr_ptr", int'(rr_ptr), e.rr);
                check("latency", cyc - e.c0, e.k);
                check("busy_cycles", busy_cnt, e.k);
            end
            check("busy_at_done", int'(busy), 0);
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [LINES-1:0] v;
        int d0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_found", int'(found), 0);
        check("reset_out", int'(out_idx), 0);
        check("reset_rr_ptr", int'(rr_ptr), LINES - 1);

        // Directed: LOW / HIGH / empty, issued back-to-back.
        v = '0; v[5] = 1'b1; v[70] = 1'b1;
        issue(MODE_LOW, v, 0, 1);
        issue(MODE_HIGH, v, 0, 1);
        issue(MODE_LOW, '0, 0, 1);
        drain();

        // Round-robin from reset: 5, 70, 5 (last one wraps through chunk 0).
        repeat (3) issue(MODE_RR, v, 0, 1);
        drain();

        // Grant in the start chunk only reachable by the final revisit.
        v = '0; v[3] = 1'b1;
        issue(MODE_RR, v, 0, 1);
        issue(MODE_RR, v, 0, 1);
        issue(MODE_RR, '0, 0, 1);
        drain();

        // Reserved mode behaves as LOW; single-line vector agrees LOW/HIGH.
        v = '0; v[5] = 1'b1; v[70] = 1'b1;
        issue(2'd3, v, 0, 1);
        v = '0; v[42] = 1'b1;
        issue(MODE_LOW, v, 0, 1);
        issue(MODE_HIGH, v, 0, 1);
        drain();

        // Random traffic, mostly back-to-back.
        for (int n = 0; n < 120; n++) begin
            issue(2'($urandom_range(0, 3)), rand_vec(), 0, 1);
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        // start held high during a scan must not queue a second search.
        d0 = done_cnt;
        v = '0; v[127] = 1'b1;
        issue(MODE_LOW, v, 1, 1);
        drain();
        check("single_done_with_start_held", done_cnt - d0, 1);

        // Move rr_ptr away from its reset value before the reset test.
        v = '0; v[9] = 1'b1;
        issue(MODE_RR, v, 0, 1);
        drain();

        // Reset during the third SCAN cycle abandons the search silently.
        d0 = done_cnt;
        issue(MODE_HIGH, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_rr = LINES - 1;
        check("midscan_reset_busy", int'(busy), 0);
        check("midscan_reset_found", int'(found), 0);
        check("midscan_reset_out", int'(out_idx), 0);
        check("midscan_reset_rr_ptr", int'(rr_ptr), LINES - 1);
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt - d0, 0);

        // Post-reset RR search starts at line 0 again.
        v = '0; v[5] = 1'b1; v[70] = 1'b1;
        issue(MODE_RR, v, 0, 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
